// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared constants for the serial bit source: FSM state encodings,
//   default word width and the level x rests at between words.
package serial_pkg;

  localparam logic [0:0] ST_IDLE       = 1'b0;
  localparam logic [0:0] ST_SHIFT      = 1'b1;

  localparam int         SER_WIDTH_DEF = 16;
  localparam logic       SER_IDLE_LVL  = 1'b1;

endpackage

// File: rtl/serial_bit_cnt.sv
// serial_bit_cnt
//   Bit-position counter for the serializer. Counts up from 0 while enabled
//   and flags the last bit of a word through tc.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset (cnt -> 0)
//     clr    synchronous clear, higher priority than en
//     en     count enable
//     tc     terminal count, high while cnt == WIDTH-1
module serial_bit_cnt
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/serial_bit_source.sv
// serial_bit_source
//   Parallel-in / serial-out stage feeding the serial sequence detector.
//   A word is accepted on load while ready, then presented one bit per
//   clock on x, starting the cycle after the accepting edge. x rests high
//   between words so the detector stays in its initial state.
//   Ports:
//     clk      rising-edge clock
//     reset    synchronous active-high reset
//     load     accept request, honoured only while ready
//     din      parallel word, sampled on the accepting edge
//     ready    a word can be accepted this cycle
//     x        serial bit (registered)
//     x_valid  x carries a word bit (registered)
//     done     pulse coincident with the last bit of a word
//   Build option: define SERIAL_MSB_FIRST_EN to send din[WIDTH-1] first;
//   default is LSB first. Timing is identical in both builds.
//
//   state    | meaning
//   ST_IDLE  | no word in flight, x at idle level, ready
//   ST_SHIFT | presenting word bits; ready only on the last bit
module serial_bit_source
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_x;
  logic             r_x_valid;

  logic             w_tc;
  logic             w_shift;
  logic             w_ready;
  logic             w_accept;
  logic             w_cnt_clr;
  logic             w_cnt_en;

  assign w_shift   = (r_state == ST_SHIFT);
  // tc cannot be high in IDLE (cnt rests at 0 and WIDTH >= 2), so it alone
  // marks the last-bit cycle.
  assign w_ready   = !w_shift || w_tc;
  assign w_accept  = load && w_ready;
  // Clearing on tc covers both the back-to-back reload and the return to IDLE.
  assign w_cnt_clr = w_accept || w_tc;
  assign w_cnt_en  = w_shift && !w_tc;

  serial_bit_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_cnt_clr),
    .en    (w_cnt_en),
    .tc    (w_tc)
  );

  // x is loaded with the first bit directly; the shift register holds the
  // remaining bits, already advanced by one position.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_x       <= SER_IDLE_LVL;
      r_x_valid <= 1'b0;
    end else if (w_accept) begin
      r_state   <= ST_SHIFT;
      r_x_valid <= 1'b1;
`ifdef SERIAL_MSB_FIRST_EN
      r_x       <= din[WIDTH-1];
      r_shreg   <= din << 1;
`else
      r_x       <= din[0];
      r_shreg   <= din >> 1;
`endif
    end else if (w_shift) begin
      if (w_tc) begin
        r_state   <= ST_IDLE;
        r_x       <= SER_IDLE_LVL;
        r_x_valid <= 1'b0;
      end else begin
`ifdef SERIAL_MSB_FIRST_EN
        r_x     <= r_shreg[WIDTH-1];
        r_shreg <= r_shreg << 1;
`else
        r_x     <= r_shreg[0];
        r_shreg <= r_shreg >> 1;
`endif
      end
    end
  end

  assign ready   = w_ready;
  assign x       = r_x;
  assign x_valid = r_x_valid;
  assign done    = w_shift && w_tc;

endmodule

// File: tb/tb_serial_bit_source.sv
// tb_serial_bit_source
//   Directed scenarios followed by random load/reset traffic, checked every
//   cycle against a queue-based model of the serial stream.
module tb_serial_bit_source;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] din;
  logic         ready;
  logic         x;
  logic         x_valid;
  logic         done;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: the bit currently on the line plus the bits still to come.
  logic m_busy  = 1'b0;
  logic m_x     = 1'b1;
  logic m_q[$];

  serial_bit_source #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .din     (din),
    .ready   (ready),
    .x       (x),
    .x_valid (x_valid),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check.
  task automatic cyc(input logic rst, input logic ld, input logic [W-1:0] d);
    logic m_ready;
    logic [W-1:0] word;
    reset = rst;
    load  = ld;
    din   = d;
    m_ready = !m_busy || (m_q.size() == 0);
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0;
      m_x    = 1'b1;
      m_q.delete();
    end else if (ld && m_ready) begin
      word = d;
      m_q.delete();
      for (int i = 0; i < W; i++) begin
`ifdef SERIAL_MSB_FIRST_EN
        m_q.push_back(word[W-1-i]);
`else
        m_q.push_back(word[i]);
`endif
      end
      m_x    = m_q.pop_front();
      m_busy = 1'b1;
    end else if (m_busy) begin
      if (m_q.size() > 0) begin
        m_x = m_q.pop_front();
      end else begin
        m_busy = 1'b0;
        m_x    = 1'b1;
      end
    end
    #1;
    chk("x",       x,       m_x);
    chk("x_valid", x_valid, m_busy);
    chk("done",    done,    m_busy && (m_q.size() == 0));
    chk("ready",   ready,   !m_busy || (m_q.size() == 0));
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    din   = '0;

    // Reset state
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    chk("rst_x_idle", x, 1'b1);

    // Single word with the documented pattern, then idle tail
    cyc(1'b0, 1'b1, 16'b0011001101011010);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, '0);

    // Back-to-back: all ones, then all zeros loaded in the done cycle
    cyc(1'b0, 1'b1, 16'hFFFF);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 16'h0000);
    chk("b2b_done1", done, 1'b1);
    cyc(1'b0, 1'b1, 16'h0000);
    chk("b2b_gapless", x_valid, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, '0);

    // Load while busy is ignored
    cyc(1'b0, 1'b1, 16'h1234);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 16'hA5A5);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, '0);

    // Reset mid-word, then a cold-style load
    cyc(1'b0, 1'b1, 16'hBEEF);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    chk("midrst_xv", x_valid, 1'b0);
    cyc(1'b0, 1'b1, 16'h8001);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, '0);

    // Reset and load on the same edge
    cyc(1'b1, 1'b1, 16'h0F0F);
    chk("rstload_xv", x_valid, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 59) == 0),
          ($urandom_range(0, 2) != 0),
          W'($urandom));
    end
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
